// File: rtl/tx_string_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the result-string serialiser.
// Character 0 of a string occupies the most significant byte.
package tx_string_sequencer_pkg;

    localparam int unsigned STR_CHARS  = 14;
    localparam int unsigned INT_DIGITS = 6;
    localparam int unsigned CHAR_W     = 8;
    localparam int unsigned STR_W      = STR_CHARS * CHAR_W;
    localparam int unsigned IDX_W      = 4;

    localparam logic [CHAR_W-1:0] ASCII_ZERO = 8'h30;
    localparam logic [CHAR_W-1:0] ASCII_CR   = 8'h0D;
    localparam logic [CHAR_W-1:0] ASCII_LF   = 8'h0A;

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(STR_CHARS - 1);
    localparam logic [IDX_W-1:0] LAST_INT_IDX = IDX_W'(INT_DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        SEND   = 3'd2,
        EOL_CR = 3'd3,
        EOL_LF = 3'd4,
        FIN    = 3'd5
    } state_t;

    // Byte offered to the UART together with its qualifier.
    typedef struct packed {
        logic              valid;
        logic [CHAR_W-1:0] data;
    } tx_beat_t;

    // Indexed character mux; indices past the last character read as zero.
    function automatic logic [CHAR_W-1:0] char_at(input logic [STR_W-1:0] s,
                                                  input logic [IDX_W-1:0] idx);
        logic [CHAR_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < STR_CHARS; i++) begin
            if (idx == IDX_W'(i)) begin
                c = s[(STR_CHARS - 1 - i) * CHAR_W +: CHAR_W];
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/tx_string_sequencer.sv
// Captures one ASCII result string per request and streams it byte-by-byte to
// the UART, optionally dropping integer leading zeros and appending CR/LF.
module tx_string_sequencer
    import tx_string_sequencer_pkg::*;
#(
    parameter bit SUPPRESS_LZ = 1'b1,
    parameter bit APPEND_EOL  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STR_W-1:0]  in_str,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CHAR_W-1:0] tx_byte,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [STR_W-1:0]  str_q;
    logic [STR_W-1:0]  str_next;
    tx_beat_t          beat_q;
    tx_beat_t          beat_next;
    logic              in_ready_q;
    logic              in_ready_next;
    logic              busy_q;
    logic              busy_next;
    logic              done_q;
    logic              done_next;

    logic              accept_c;
    logic              xfer_c;
    logic              scan_zero_c;

    assign accept_c    = in_valid && in_ready_q;
    assign xfer_c      = beat_q.valid && tx_ready;
    assign scan_zero_c = (char_at(str_q, idx) == ASCII_ZERO) && (idx < LAST_INT_IDX);

    // State, index, captured string and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            str_q      <= '0;
            beat_q     <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            str_q      <= str_next;
            beat_q     <= beat_next;
            in_ready_q <= in_ready_next;
            busy_q     <= busy_next;
            done_q     <= done_next;
        end
    end

    // Next state plus the output values that state will present.
    always_comb begin
        state_next    = state;
        idx_next      = idx;
        str_next      = str_q;
        beat_next     = '0;
        in_ready_next = 1'b0;
        busy_next     = 1'b1;
        done_next     = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept_c) begin
                    str_next   = in_str;
                    idx_next   = '0;
                    state_next = SUPPRESS_LZ ? SCAN : SEND;
                end
            end
            SCAN: begin
                if (scan_zero_c) begin
                    idx_next = idx + IDX_W'(1);
                end else begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (xfer_c) begin
                    if (idx == LAST_IDX) begin
                        state_next = APPEND_EOL ? EOL_CR : FIN;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
            end
            EOL_CR: begin
                if (xfer_c) begin
                    state_next = EOL_LF;
                end
            end
            EOL_LF: begin
                if (xfer_c) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the upcoming state.
        unique case (state_next)
            SEND: begin
                beat_next.valid = 1'b1;
                beat_next.data  = char_at(str_next, idx_next);
            end
            EOL_CR: begin
                beat_next.valid = 1'b1;
                beat_next.data  = ASCII_CR;
            end
            EOL_LF: begin
                beat_next.valid = 1'b1;
                beat_next.data  = ASCII_LF;
            end
            FIN: begin
                done_next = 1'b1;
            end
            IDLE: begin
                in_ready_next = 1'b1;
                busy_next     = 1'b0;
            end
            default: begin
                beat_next = '0;
            end
        endcase
    end

    assign in_ready = in_ready_q;
    assign tx_byte  = beat_q.data;
    assign tx_valid = beat_q.valid;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_tx_string_sequencer.sv
// Randomised bench for tx_string_sequencer: two instances (suppress+EOL, plain)
// checked every cycle against a queue-style model of the expected byte stream.
module tb_tx_string_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [111:0] in_str;
    logic         in_valid [2];
    logic         in_ready [2];
    logic [7:0]   tx_byte  [2];
    logic         tx_valid [2];
    logic         tx_ready;
    logic         busy     [2];
    logic         done     [2];

    int checks   = 0;
    int failures = 0;
    int ready_div = 1;
    bit mon_en = 1'b0;

    bit           slz_p    [2];
    bit           eol_p    [2];
    bit           active   [2];
    bit           done_due [2];
    bit           stall_prev [2];
    logic [7:0]   prev_byte [2];
    logic [111:0] cap      [2];
    int           pos      [2];
    int           len      [2];
    int           lat      [2];
    int           lat0     [2];
    int           xfer_cnt [2];

    always #5 clk = ~clk;

    tx_string_sequencer #(.SUPPRESS_LZ(1'b1), .APPEND_EOL(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_str(in_str), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .tx_byte(tx_byte[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready), .busy(busy[0]), .done(done[0])
    );

    tx_string_sequencer #(.SUPPRESS_LZ(1'b0), .APPEND_EOL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_str(in_str), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .tx_byte(tx_byte[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready), .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Expected stream: chars from the first kept integer digit through '>', then CR LF.
    function automatic logic [7:0] ch(input logic [111:0] s, input int k);
        return s[(13 - k) * 8 +: 8];
    endfunction

    function automatic int model_start(input logic [111:0] s, input bit slz);
        int st = 0;
        if (slz) begin
            while (st < 5 && ch(s, st) == 8'h30) st++;
        end
        return st;
    endfunction

    function automatic int model_len(input logic [111:0] s, input bit slz, input bit eol);
        return 14 - model_start(s, slz) + (eol ? 2 : 0);
    endfunction

    // Negedges from accept to first tx_valid: one scan cycle per examined char.
    function automatic int model_lat(input logic [111:0] s, input bit slz);
        return slz ? model_start(s, slz) + 2 : 1;
    endfunction

    function automatic logic [7:0] model_byte(input logic [111:0] s, input bit slz,
                                              input bit eol, input int k);
        int p = model_start(s, slz) + k;
        if (p < 14) return ch(s, p);
        if (p == 14 && eol) return 8'h0D;
        return 8'h0A;
    endfunction

    function automatic logic [111:0] rand_str();
        logic [111:0] s;
        logic [7:0]   c;
        int lz = int'($urandom_range(0, 6));
        s = '0;
        for (int k = 0; k < 14; k++) begin
            if (k == 6)       c = 8'h2E;
            else if (k == 13) c = 8'h3E;
            else if (k < lz)  c = 8'h30;
            else if ($urandom_range(0, 11) == 0) c = 8'h41 + 8'($urandom_range(0, 5));
            else              c = 8'h30 + 8'($urandom_range(0, 9));
            s[(13 - k) * 8 +: 8] = c;
        end
        return s;
    endfunction

    always @(posedge clk) begin
        #1;
        tx_ready = (ready_div <= 1) ? 1'b1 : ($urandom_range(0, ready_div - 1) == 0);
    end

    // Compare process: every cycle, both instances against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                bit ev;
                bit nd;
                ev = active[d] && (pos[d] < len[d]) && (lat[d] >= lat0[d]);
                check("tx_valid", d, 32'(tx_valid[d]), 32'(ev));
                check("busy", d, 32'(busy[d]), 32'(active[d]));
                check("in_ready", d, 32'(in_ready[d]), 32'(!active[d]));
                check("done", d, 32'(done[d]), 32'(done_due[d]));
                if (ev && tx_valid[d] === 1'b1)
                    check("tx_byte", d, 32'(tx_byte[d]),
                          32'(model_byte(cap[d], slz_p[d], eol_p[d], pos[d])));
                if (stall_prev[d])
                    check("stall_hold", d, {23'd0, tx_valid[d], tx_byte[d]},
                          {23'd0, 1'b1, prev_byte[d]});
                if (!rst_n) begin
                    active[d]     = 1'b0;
                    done_due[d]   = 1'b0;
                    stall_prev[d] = 1'b0;
                end else begin
                    stall_prev[d] = (tx_valid[d] === 1'b1) && !tx_ready;
                    prev_byte[d]  = tx_byte[d];
                    nd = 1'b0;
                    if (ev && tx_ready) begin
                        pos[d]++;
                        xfer_cnt[d]++;
                        if (pos[d] == len[d]) nd = 1'b1;
                    end
                    if (active[d]) lat[d]++;
                    if (done_due[d]) begin
                        active[d] = 1'b0;
                    end else if (!active[d] && in_valid[d]) begin
                        cap[d]    = in_str;
                        pos[d]    = 0;
                        len[d]    = model_len(in_str, slz_p[d], eol_p[d]);
                        lat0[d]   = model_lat(in_str, slz_p[d]);
                        lat[d]    = 1;
                        active[d] = 1'b1;
                    end
                    done_due[d] = nd;
                end
            end
        end
    end

    task automatic check_idle_outputs(input string name);
        for (int d = 0; d < 2; d++) begin
            check({name, "_tx_valid"}, d, 32'(tx_valid[d]), 32'd0);
            check({name, "_tx_byte"}, d, 32'(tx_byte[d]), 32'd0);
            check({name, "_busy"}, d, 32'(busy[d]), 32'd0);
            check({name, "_in_ready"}, d, 32'(in_ready[d]), 32'd1);
            check({name, "_done"}, d, 32'(done[d]), 32'd0);
        end
    endtask

    task automatic run_frame(input int d, input logic [111:0] s, input int rdiv,
                             input bit garbage);
        int n = 0;
        ready_div = rdiv;
        @(posedge clk); #1;
        in_str = s;
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        while (active[d] && n < 2000) begin
            if (garbage && $urandom_range(0, 3) == 0) begin
                in_str = rand_str();
                in_valid[d] = 1'b1;
            end
            @(posedge clk); #1;
            in_valid[d] = 1'b0;
            n++;
        end
        if (active[d]) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout dut%0d: frame still active after %0d cycles", d, n);
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_frame(input logic [111:0] s);
        int n = 0;
        int base = xfer_cnt[0];
        ready_div = 1;
        @(posedge clk); #1;
        in_str = s;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        while (xfer_cnt[0] < base + 4 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("xfers_before_reset", 0, 32'(xfer_cnt[0] - base), 32'd4);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("mid_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [111:0] s_basic;
        logic [111:0] s_zero;
        logic [111:0] s_plain;
        s_basic = "000123.450000>";
        s_zero  = "000000.000000>";
        s_plain = "987654.321098>";

        slz_p[0] = 1'b1; eol_p[0] = 1'b1;
        slz_p[1] = 1'b0; eol_p[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            active[d] = 1'b0; done_due[d] = 1'b0; stall_prev[d] = 1'b0;
            prev_byte[d] = '0; cap[d] = '0; pos[d] = 0; len[d] = 0;
            lat[d] = 0; lat0[d] = 0; xfer_cnt[d] = 0;
            in_valid[d] = 1'b0;
        end
        rst_n    = 1'b0;
        in_str   = '0;
        tx_ready = 1'b1;

        // Hand-computed anchors for the model itself.
        check("pin_basic_len", 0, 32'(model_len(s_basic, 1'b1, 1'b1)), 32'd13);
        check("pin_basic_b0", 0, 32'(model_byte(s_basic, 1'b1, 1'b1, 0)), 32'h31);
        check("pin_basic_b3", 0, 32'(model_byte(s_basic, 1'b1, 1'b1, 3)), 32'h2E);
        check("pin_basic_b10", 0, 32'(model_byte(s_basic, 1'b1, 1'b1, 10)), 32'h3E);
        check("pin_basic_b11", 0, 32'(model_byte(s_basic, 1'b1, 1'b1, 11)), 32'h0D);
        check("pin_basic_b12", 0, 32'(model_byte(s_basic, 1'b1, 1'b1, 12)), 32'h0A);
        check("pin_basic_lat", 0, 32'(model_lat(s_basic, 1'b1)), 32'd5);
        check("pin_zero_len", 0, 32'(model_len(s_zero, 1'b1, 1'b1)), 32'd11);
        check("pin_zero_b0", 0, 32'(model_byte(s_zero, 1'b1, 1'b1, 0)), 32'h30);
        check("pin_zero_b1", 0, 32'(model_byte(s_zero, 1'b1, 1'b1, 1)), 32'h2E);
        check("pin_zero_lat", 0, 32'(model_lat(s_zero, 1'b1)), 32'd7);
        check("pin_plain_len", 1, 32'(model_len(s_plain, 1'b0, 1'b0)), 32'd14);
        check("pin_plain_b0", 1, 32'(model_byte(s_plain, 1'b0, 1'b0, 0)), 32'h39);
        check("pin_plain_b13", 1, 32'(model_byte(s_plain, 1'b0, 1'b0, 13)), 32'h3E);
        check("pin_plain_lat", 1, 32'(model_lat(s_plain, 1'b0)), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        run_frame(0, s_basic, 1, 1'b0);
        run_frame(0, s_zero, 1, 1'b0);
        run_frame(1, s_plain, 1, 1'b0);
        run_frame(0, s_basic, 3, 1'b0);
        run_frame(1, s_plain, 3, 1'b0);
        run_frame(0, "000042.000001>", 2, 1'b1);
        run_frame(1, "000042.000001>", 2, 1'b1);
        reset_mid_frame(s_plain);
        run_frame(0, "100000.000000>", 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_frame(int'($urandom_range(0, 1)), rand_str(),
                      int'($urandom_range(1, 4)), bit'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tx_string_sequencer.md
Name: tx_string_sequencer

Overview:
- Serialises the 14-character ASCII result string (6 integer digits, '.', 6 fraction digits, '>') into a byte stream for the UART transmitter.
- Sits between the BCD-to-ASCII output stage and the UART TX block.
- Captures one string per request and optionally suppresses integer leading zeros.
- Optionally appends CR/LF, then signals completion.

Parameters:
- SUPPRESS_LZ, 1, when 1 skip leading '0' characters of the integer field, always keeping the last integer digit.
- APPEND_EOL, 1, when 1 send 0x0D then 0x0A after the '>' character.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  synchronous active-low reset.
- in_str  input  112  ASCII string; char 0 = [111:104] … char 13 = [7:0].
- in_valid  input  1  request to send in_str.
- in_ready  output  1  block can accept a string (IDLE only).
- tx_byte  output  8  byte offered to the UART.
- tx_valid  output  1  tx_byte is valid.
- tx_ready  input  1  UART accepts the byte this cycle.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- One clock; reset is synchronous and active-low: rst_n sampled low at a clk rising edge forces the following:
  - state=IDLE, tx_valid=0, tx_byte=8'h00, done=0, busy=0, in_ready=1.
  - Character index=0, captured string register cleared.
  - This applies mid-frame too. An in-flight byte is abandoned with no further bytes and no done pulse.
- Handshakes:
  - Upstream accept: in_valid && in_ready at a clock edge.
  - UART transfer: tx_valid && tx_ready at a clock edge.
  - Once tx_valid is asserted, tx_valid and tx_byte hold stable until the transfer occurs.
- States:
  - IDLE: in_ready=1. On accept, latch in_str, set idx=0, go to SCAN if SUPPRESS_LZ=1, else go to SEND.
  - SCAN: one cycle per examined char. If char[idx]==8'h30 and idx<5, idx++ and stay. Otherwise go to SEND. Worst case 6 cycles (idx reaches 5).
  - SEND: tx_valid=1, tx_byte=char[idx]. On transfer:
    - If idx<13: idx++.
    - If idx==13: go to EOL_CR if APPEND_EOL=1, else go to FIN.
  - EOL_CR: tx_byte=8'h0D, tx_valid=1. On transfer go to EOL_LF.
  - EOL_LF: tx_byte=8'h0A, tx_valid=1. On transfer go to FIN.
  - FIN: done=1 for exactly one cycle, tx_valid=0, then IDLE.
- Latency:
  - First tx_valid appears the cycle after accept (SUPPRESS_LZ=0), or after SCAN completes.
  - With tx_ready held high, one byte is transferred per cycle.
- Timing rules:
  - tx_valid deasserts in the cycle after the last transfer.
  - in_ready returns to 1 the cycle after done.
  - in_valid while busy is ignored. No queuing; the upstream block must hold or retry.
- Captured string: in_str is captured only at accept. Changes to in_str during a frame do not affect output.
- Index: idx is 4 bits, range 0..13. No wrap; the 13→next transition is state-driven.
- Zero suppression acts only on the integer field, chars 0..5. Char 6 ('.') and later are always sent.
- The block checks no character other than 8'h30 during SCAN. Non-digit input is passed through unchanged.

Decomposition:
- Shared package holds the following constants:
  - ASCII_ZERO=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
  - STR_CHARS=14, INT_DIGITS=6.
  - The state enum: IDLE, SCAN, SEND, EOL_CR, EOL_LF, FIN.
- No sub-module. Character selection is an indexed mux inside the block.

Test Plan:
- Basic frame: in_str="000123.450000>", SUPPRESS_LZ=1, APPEND_EOL=1, tx_ready=1 → bytes 31 32 33 2E 34 35 30 30 30 30 3E 0D 0A (13 bytes), single done pulse, busy low the cycle after done.
- All zero: in_str="000000.000000>", SUPPRESS_LZ=1 → first byte 30 (one integer digit kept), then 2E 30×6 3E 0D 0A; SCAN lasts 6 cycles.
- No suppression, no EOL: "987654.321098>", SUPPRESS_LZ=0, APPEND_EOL=0 → exactly 14 bytes in order; first tx_valid one cycle after accept.
- Backpressure: random tx_ready (e.g. 1 cycle in 3 high) → tx_byte/tx_valid stable while stalled; byte sequence identical to the no-stall case.
- Busy/ignore: pulse in_valid with a different in_str mid-frame → ignored; in_ready=0; output unchanged; next accept only after done.
- Reset mid-frame: assert rst_n=0 after the 4th transfer → next cycle tx_valid=0, busy=0, in_ready=1, no done pulse; a new frame afterwards starts from char 0.
